// File: rtl/decode_stage_pipelined_if.sv
// Bundles the decode stage's IF/ID, control, write-back and ID/EX signals.
// The slave modport is the decode stage; the master modport is whatever drives it.
interface decode_stage_pipelined_if #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 24,
  parameter int RAW    = 5
);
  logic              if_valid;
  logic [31:0]       if_instr;
  logic [XLEN-1:0]   if_pc4;
  logic              id_ready;
  logic [4:0]        opcode;
  logic [CTRL_W-1:0] ctrl_in;
  logic              flush;
  logic              ex_ready;
  logic              wb_we;
  logic [RAW-1:0]    wb_rd;
  logic [XLEN-1:0]   wb_data;
  logic [XLEN-1:0]   br_target;
  logic [XLEN-1:0]   jmp_target;
  logic [XLEN-1:0]   call_rs1;
  logic              eq;
  logic              ex_valid;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [XLEN-1:0]   ex_busA;
  logic [XLEN-1:0]   ex_busB;
  logic [XLEN-1:0]   ex_imm;
  logic [RAW-1:0]    ex_rd;
  logic [XLEN-1:0]   ex_pc4;

  modport master (
    output if_valid, if_instr, if_pc4, ctrl_in, flush, ex_ready, wb_we, wb_rd, wb_data,
    input  id_ready, opcode, br_target, jmp_target, call_rs1, eq,
    input  ex_valid, ex_ctrl, ex_busA, ex_busB, ex_imm, ex_rd, ex_pc4
  );

  modport slave (
    input  if_valid, if_instr, if_pc4, ctrl_in, flush, ex_ready, wb_we, wb_rd, wb_data,
    output id_ready, opcode, br_target, jmp_target, call_rs1, eq,
    output ex_valid, ex_ctrl, ex_busA, ex_busB, ex_imm, ex_rd, ex_pc4
  );
endinterface

// File: rtl/decode_stage_pipelined.sv
// Decode stage: register file with write-back bypass, branch/jump targets, and a
// registered ID/EX boundary with load-use stall, flush and execute backpressure.
module decode_stage_pipelined #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int CTRL_W   = 24
) (
  input logic clk,
  input logic reset,
  decode_stage_pipelined_if.slave bus
);
  localparam int RAW = $clog2(NUM_REGS);

  logic [4:0]      rd_f;
  logic [4:0]      rs1_f;
  logic [4:0]      rs2_f;
  logic [16:0]     imm17;
  logic [26:0]     target27;
  logic            ra_dst;
  logic            rb_dst;
  logic            ext_op;
  logic [RAW-1:0]  ra;
  logic [RAW-1:0]  rb;
  logic [RAW-1:0]  rd;
  logic [XLEN-1:0] imm_ext;
  logic [XLEN-1:0] bus_a;
  logic [XLEN-1:0] bus_b;
  logic            hazard;

  logic [XLEN-1:0]     regs [NUM_REGS];
  logic [NUM_REGS-1:0] wr_en;

  logic              ex_valid_reg;
  logic [CTRL_W-1:0] ex_ctrl_reg;
  logic [XLEN-1:0]   ex_bus_a_reg;
  logic [XLEN-1:0]   ex_bus_b_reg;
  logic [XLEN-1:0]   ex_imm_reg;
  logic [RAW-1:0]    ex_rd_reg;
  logic [XLEN-1:0]   ex_pc4_reg;

  assign rd_f     = bus.if_instr[26:22];
  assign rs1_f    = bus.if_instr[21:17];
  assign rs2_f    = bus.if_instr[16:12];
  assign imm17    = bus.if_instr[16:0];
  assign target27 = bus.if_instr[26:0];
  assign ra_dst   = bus.ctrl_in[0];
  assign rb_dst   = bus.ctrl_in[1];
  assign ext_op   = bus.ctrl_in[2];

  assign ra = ra_dst ? rd_f[RAW-1:0] : rs1_f[RAW-1:0];
  assign rb = rb_dst ? rs2_f[RAW-1:0] : rd_f[RAW-1:0];
  assign rd = rd_f[RAW-1:0];

  assign imm_ext = {{(XLEN-17){ext_op & imm17[16]}}, imm17};

  // Register 0 never gets a write enable, so it stays at its reset value of zero.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_wr_en
    if (gi == 0) begin : g_zero
      assign wr_en[gi] = 1'b0;
    end else begin : g_file
      assign wr_en[gi] = bus.wb_we && (int'(bus.wb_rd) == gi);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (!reset) begin
        regs[i] <= '0;
      end else if (wr_en[i]) begin
        regs[i] <= bus.wb_data;
      end
    end
  end

  // Reads of indices beyond the file (non power-of-two NUM_REGS) return zero.
  always_comb begin
    bus_a = '0;
    if (ra != '0 && int'(ra) < NUM_REGS) begin
      if (bus.wb_we && bus.wb_rd == ra) bus_a = bus.wb_data;
      else                              bus_a = regs[ra];
    end
  end

  always_comb begin
    bus_b = '0;
    if (rb != '0 && int'(rb) < NUM_REGS) begin
      if (bus.wb_we && bus.wb_rd == rb) bus_b = bus.wb_data;
      else                              bus_b = regs[rb];
    end
  end

  assign hazard = bus.if_valid && ex_valid_reg && ex_ctrl_reg[3] && (ex_rd_reg != '0) &&
                  ((ex_rd_reg == ra) || (ex_rd_reg == rb));

  assign bus.id_ready   = reset && (bus.flush || (bus.ex_ready && !hazard));
  assign bus.opcode     = bus.if_instr[31:27];
  assign bus.br_target  = bus.if_pc4 + (imm_ext << 2);
  assign bus.jmp_target = {bus.if_pc4[XLEN-1:29], target27, 2'b00};
  assign bus.call_rs1   = bus_a;
  assign bus.eq         = (bus_a == bus_b);

  // A stalled (hazard) cycle only clears valid/ctrl; the data fields are don't-care then.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ex_valid_reg <= 1'b0;
      ex_ctrl_reg  <= '0;
      ex_bus_a_reg <= '0;
      ex_bus_b_reg <= '0;
      ex_imm_reg   <= '0;
      ex_rd_reg    <= '0;
      ex_pc4_reg   <= '0;
    end else if (bus.flush) begin
      ex_valid_reg <= 1'b0;
    end else if (bus.ex_ready) begin
      if (hazard) begin
        ex_valid_reg <= 1'b0;
        ex_ctrl_reg  <= '0;
      end else begin
        ex_valid_reg <= bus.if_valid;
        ex_ctrl_reg  <= bus.if_valid ? bus.ctrl_in : '0;
        ex_bus_a_reg <= bus_a;
        ex_bus_b_reg <= bus_b;
        ex_imm_reg   <= imm_ext;
        ex_rd_reg    <= rd;
        ex_pc4_reg   <= bus.if_pc4;
      end
    end
  end

  assign bus.ex_valid = ex_valid_reg;
  assign bus.ex_ctrl  = ex_ctrl_reg;
  assign bus.ex_busA  = ex_bus_a_reg;
  assign bus.ex_busB  = ex_bus_b_reg;
  assign bus.ex_imm   = ex_imm_reg;
  assign bus.ex_rd    = ex_rd_reg;
  assign bus.ex_pc4   = ex_pc4_reg;
endmodule

// File: tb/tb_decode_stage_pipelined.sv
// Self-checking bench for decode_stage_pipelined: directed scenarios followed by a
// randomized run against a behavioural model of the stage.
module tb_decode_stage_pipelined;
  localparam int XLEN = 32, NUM_REGS = 32, CTRL_W = 24, RAW = 5;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  decode_stage_pipelined_if #(.XLEN(XLEN), .CTRL_W(CTRL_W), .RAW(RAW)) bus ();

  decode_stage_pipelined #(.XLEN(XLEN), .NUM_REGS(NUM_REGS), .CTRL_W(CTRL_W)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [16:0] imm);
    return {op, rd, rs1, imm};
  endfunction

  task automatic idle();
    bus.if_valid = 1'b0; bus.if_instr = '0; bus.if_pc4 = '0; bus.ctrl_in = '0;
    bus.flush = 1'b0; bus.ex_ready = 1'b1; bus.wb_we = 1'b0; bus.wb_rd = '0; bus.wb_data = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b0;
    repeat (2) tick();
    n_checks++; if (bus.ex_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ex_valid: got %b expected 0", bus.ex_valid); end
    n_checks++; if (bus.ex_ctrl !== 24'h0) begin n_fail++; $display("FAIL reset_ex_ctrl: got %h expected 0", bus.ex_ctrl); end
    n_checks++; if (bus.id_ready !== 1'b0) begin n_fail++; $display("FAIL reset_id_ready: got %b expected 0", bus.id_ready); end
    reset = 1'b1;
    tick();
    n_checks++; if (bus.ex_valid !== 1'b0) begin n_fail++; $display("FAIL release_ex_valid: got %b expected 0", bus.ex_valid); end
    for (int r = 1; r < 32; r++) begin
      bus.if_valid = 1'b1; bus.ctrl_in = '0;
      bus.if_instr = mk(5'd1, 5'(r), 5'(r), 17'd0);
      @(negedge clk);
      n_checks++; if (bus.call_rs1 !== 32'h0) begin n_fail++; $display("FAIL reset_read_r%0d: got %h expected 0", r, bus.call_rs1); end
      n_checks++; if (bus.eq !== 1'b1) begin n_fail++; $display("FAIL reset_eq_r%0d: got %b expected 1", r, bus.eq); end
      tick();
    end
    idle();
    tick();
  endtask

  task automatic test_bypass();
    bus.wb_we = 1'b1; bus.wb_rd = 5'd5; bus.wb_data = 32'hDEADBEEF;
    bus.if_valid = 1'b1; bus.ctrl_in = '0; bus.if_instr = mk(5'd2, 5'd9, 5'd5, 17'd0);
    @(negedge clk);
    n_checks++; if (bus.call_rs1 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL bypass_call_rs1: got %h expected deadbeef", bus.call_rs1); end
    n_checks++; if (bus.eq !== 1'b0) begin n_fail++; $display("FAIL bypass_eq: got %b expected 0", bus.eq); end
    tick();
    n_checks++; if (bus.ex_busA !== 32'hDEADBEEF) begin n_fail++; $display("FAIL bypass_ex_busA: got %h expected deadbeef", bus.ex_busA); end
    n_checks++; if (bus.ex_rd !== 5'd9) begin n_fail++; $display("FAIL bypass_ex_rd: got %0d expected 9", bus.ex_rd); end
    bus.wb_we = 1'b0; bus.if_instr = mk(5'd2, 5'd5, 5'd5, 17'd0);
    @(negedge clk);
    n_checks++; if (bus.eq !== 1'b1 || bus.call_rs1 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL file_read_r5: got %h/%b expected deadbeef/1", bus.call_rs1, bus.eq); end
    tick();
    bus.wb_we = 1'b1; bus.wb_rd = 5'd0; bus.wb_data = 32'h12345678; bus.if_instr = mk(5'd2, 5'd0, 5'd0, 17'd0);
    @(negedge clk);
    n_checks++; if (bus.call_rs1 !== 32'h0) begin n_fail++; $display("FAIL r0_bypass: got %h expected 0", bus.call_rs1); end
    tick();
    bus.wb_we = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.call_rs1 !== 32'h0) begin n_fail++; $display("FAIL r0_write: got %h expected 0", bus.call_rs1); end
    tick();
    idle();
  endtask

  task automatic test_load_use();
    bus.if_valid = 1'b1; bus.ctrl_in = 24'h18; bus.if_instr = mk(5'd3, 5'd7, 5'd0, 17'd0); bus.if_pc4 = 32'h20;
    @(negedge clk);
    n_checks++; if (bus.id_ready !== 1'b1) begin n_fail++; $display("FAIL load_accept: got %b expected 1", bus.id_ready); end
    tick();
    n_checks++; if (bus.ex_valid !== 1'b1 || bus.ex_rd !== 5'd7) begin n_fail++; $display("FAIL load_in_ex: got %b/%0d expected 1/7", bus.ex_valid, bus.ex_rd); end
    bus.ctrl_in = 24'h10; bus.if_instr = mk(5'd4, 5'd3, 5'd7, 17'd0); bus.if_pc4 = 32'h24;
    @(negedge clk);
    n_checks++; if (bus.id_ready !== 1'b0) begin n_fail++; $display("FAIL load_use_stall: got %b expected 0", bus.id_ready); end
    tick();
    n_checks++; if (bus.ex_valid !== 1'b0 || bus.ex_ctrl !== 24'h0) begin n_fail++; $display("FAIL bubble: got %b/%h expected 0/0", bus.ex_valid, bus.ex_ctrl); end
    @(negedge clk);
    n_checks++; if (bus.id_ready !== 1'b1) begin n_fail++; $display("FAIL after_bubble_ready: got %b expected 1", bus.id_ready); end
    tick();
    n_checks++; if (bus.ex_valid !== 1'b1 || bus.ex_rd !== 5'd3 || bus.ex_ctrl !== 24'h10) begin
      n_fail++; $display("FAIL dependent_enters_ex: got %b/%0d/%h expected 1/3/10", bus.ex_valid, bus.ex_rd, bus.ex_ctrl); end
    idle();
  endtask

  task automatic test_backpressure();
    bus.if_valid = 1'b1; bus.ctrl_in = 24'h10; bus.if_instr = mk(5'd5, 5'd3, 5'd1, 17'd0); bus.if_pc4 = 32'h40;
    tick();
    bus.if_instr = mk(5'd5, 5'd4, 5'd1, 17'd0); bus.if_pc4 = 32'h44; bus.ex_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if (bus.id_ready !== 1'b0) begin n_fail++; $display("FAIL bp_id_ready_%0d: got %b expected 0", i, bus.id_ready); end
      tick();
      n_checks++; if (bus.ex_valid !== 1'b1 || bus.ex_rd !== 5'd3 || bus.ex_pc4 !== 32'h40) begin
        n_fail++; $display("FAIL bp_hold_%0d: got %b/%0d/%h expected 1/3/40", i, bus.ex_valid, bus.ex_rd, bus.ex_pc4); end
    end
    bus.ex_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.id_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b expected 1", bus.id_ready); end
    tick();
    n_checks++; if (bus.ex_rd !== 5'd4 || bus.ex_pc4 !== 32'h44) begin n_fail++; $display("FAIL bp_release_load: got %0d/%h expected 4/44", bus.ex_rd, bus.ex_pc4); end
    idle();
  endtask

  task automatic test_flush_hazard();
    bus.if_valid = 1'b1; bus.ctrl_in = 24'h18; bus.if_instr = mk(5'd3, 5'd7, 5'd0, 17'd0);
    tick();
    bus.ctrl_in = 24'h10; bus.if_instr = mk(5'd4, 5'd2, 5'd7, 17'd0); bus.flush = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.id_ready !== 1'b1) begin n_fail++; $display("FAIL flush_hazard_ready: got %b expected 1", bus.id_ready); end
    tick();
    n_checks++; if (bus.ex_valid !== 1'b0) begin n_fail++; $display("FAIL flush_ex_valid: got %b expected 0", bus.ex_valid); end
    idle();
  endtask

  task automatic test_reset_mid_stall();
    bus.if_valid = 1'b1; bus.ctrl_in = 24'h18; bus.if_instr = mk(5'd3, 5'd7, 5'd0, 17'd0);
    tick();
    bus.ctrl_in = 24'h10; bus.if_instr = mk(5'd4, 5'd2, 5'd7, 17'd0); bus.ex_ready = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.id_ready !== 1'b0) begin n_fail++; $display("FAIL stall_before_reset: got %b expected 0", bus.id_ready); end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    n_checks++; if (bus.ex_valid !== 1'b0 || bus.ex_ctrl !== 24'h0) begin n_fail++; $display("FAIL mid_stall_reset: got %b/%h expected 0/0", bus.ex_valid, bus.ex_ctrl); end
    idle();
    bus.if_valid = 1'b1; bus.if_instr = mk(5'd2, 5'd0, 5'd5, 17'd0);
    @(negedge clk);
    n_checks++; if (bus.call_rs1 !== 32'h0) begin n_fail++; $display("FAIL reset_clears_r5: got %h expected 0", bus.call_rs1); end
    tick();
    idle();
  endtask

  task automatic test_imm_targets();
    bus.if_valid = 1'b1; bus.ctrl_in = 24'h4; bus.if_instr = mk(5'd17, 5'd0, 5'd0, 17'h1FFFF); bus.if_pc4 = 32'h100;
    @(negedge clk);
    n_checks++; if (bus.br_target !== 32'hFC) begin n_fail++; $display("FAIL br_target_neg: got %h expected fc", bus.br_target); end
    n_checks++; if (bus.opcode !== 5'd17) begin n_fail++; $display("FAIL opcode: got %0d expected 17", bus.opcode); end
    tick();
    n_checks++; if (bus.ex_imm !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL imm_sext: got %h expected ffffffff", bus.ex_imm); end
    bus.ctrl_in = 24'h0;
    @(negedge clk);
    n_checks++; if (bus.br_target !== 32'h000800FC) begin n_fail++; $display("FAIL br_target_zext: got %h expected 000800fc", bus.br_target); end
    tick();
    n_checks++; if (bus.ex_imm !== 32'h0001FFFF) begin n_fail++; $display("FAIL imm_zext: got %h expected 0001ffff", bus.ex_imm); end
    bus.if_instr = {5'd2, 27'h10}; bus.if_pc4 = 32'hE0000000;
    @(negedge clk);
    n_checks++; if (bus.jmp_target !== 32'hE0000040) begin n_fail++; $display("FAIL jmp_target: got %h expected e0000040", bus.jmp_target); end
    tick();
    idle();
  endtask

  task automatic test_random(input int cycles);
    logic [31:0] m_regs [32];
    logic        m_valid;
    logic [23:0] m_ctrl;
    logic [31:0] m_a, m_b, m_imm, m_pc4;
    logic [4:0]  m_rd;
    idle();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    foreach (m_regs[i]) m_regs[i] = '0;
    m_valid = 1'b0; m_ctrl = '0; m_a = '0; m_b = '0; m_imm = '0; m_pc4 = '0; m_rd = '0;
    for (int c = 0; c < cycles; c++) begin
      logic [4:0]  f_rd, f_rs1, f_rs2, ra, rb;
      logic [31:0] a, b, e_imm, e_br, e_jmp;
      logic        hz, rdy, rst_now;
      int          v;
      rst_now = ($urandom_range(0, 49) == 0);
      f_rd  = 5'($urandom_range(0, 7));
      f_rs1 = 5'($urandom_range(0, 7));
      f_rs2 = 5'($urandom_range(0, 7));
      bus.if_valid = ($urandom_range(0, 3) != 0);
      bus.if_instr = {5'($urandom), f_rd, f_rs1, f_rs2, 12'($urandom)};
      bus.if_pc4   = $urandom;
      bus.ctrl_in  = 24'($urandom);
      bus.flush    = ($urandom_range(0, 9) == 0);
      bus.ex_ready = ($urandom_range(0, 4) != 0);
      bus.wb_we    = 1'($urandom_range(0, 1));
      bus.wb_rd    = 5'($urandom_range(0, 7));
      bus.wb_data  = $urandom;
      reset = !rst_now;
      ra = bus.ctrl_in[0] ? f_rd : f_rs1;
      rb = bus.ctrl_in[1] ? f_rs2 : f_rd;
      a = (ra == 0) ? 32'h0 : (bus.wb_we && bus.wb_rd == ra) ? bus.wb_data : m_regs[ra];
      b = (rb == 0) ? 32'h0 : (bus.wb_we && bus.wb_rd == rb) ? bus.wb_data : m_regs[rb];
      v = int'(bus.if_instr[16:0]);
      if (bus.ctrl_in[2] && v >= 65536) v = v - 131072;
      e_imm = 32'(v);
      e_br  = bus.if_pc4 + 32'(v * 4);
      e_jmp = (bus.if_pc4 & 32'hE000_0000) | 32'(int'(bus.if_instr[26:0]) * 4);
      hz  = bus.if_valid && m_valid && m_ctrl[3] && (m_rd != 0) && (m_rd == ra || m_rd == rb);
      rdy = !rst_now && (bus.flush || (bus.ex_ready && !hz));
      @(negedge clk);
      n_checks++; if (bus.id_ready !== rdy) begin n_fail++; $display("FAIL rnd%0d id_ready: got %b expected %b", c, bus.id_ready, rdy); end
      n_checks++; if (bus.call_rs1 !== a) begin n_fail++; $display("FAIL rnd%0d call_rs1: got %h expected %h", c, bus.call_rs1, a); end
      n_checks++; if (bus.eq !== (a == b)) begin n_fail++; $display("FAIL rnd%0d eq: got %b expected %b", c, bus.eq, (a == b)); end
      n_checks++; if (bus.br_target !== e_br) begin n_fail++; $display("FAIL rnd%0d br_target: got %h expected %h", c, bus.br_target, e_br); end
      n_checks++; if (bus.jmp_target !== e_jmp) begin n_fail++; $display("FAIL rnd%0d jmp_target: got %h expected %h", c, bus.jmp_target, e_jmp); end
      n_checks++; if (bus.opcode !== bus.if_instr[31:27]) begin n_fail++; $display("FAIL rnd%0d opcode: got %h expected %h", c, bus.opcode, bus.if_instr[31:27]); end
      if (rst_now) begin
        foreach (m_regs[i]) m_regs[i] = '0;
        m_valid = 1'b0; m_ctrl = '0; m_a = '0; m_b = '0; m_imm = '0; m_pc4 = '0; m_rd = '0;
      end else begin
        if (bus.wb_we && bus.wb_rd != 0) m_regs[bus.wb_rd] = bus.wb_data;
        if (bus.flush) begin
          m_valid = 1'b0;
        end else if (bus.ex_ready && hz) begin
          m_valid = 1'b0; m_ctrl = '0;
        end else if (bus.ex_ready) begin
          m_valid = bus.if_valid; m_ctrl = bus.if_valid ? bus.ctrl_in : 24'h0;
          m_a = a; m_b = b; m_imm = e_imm; m_rd = f_rd; m_pc4 = bus.if_pc4;
        end
      end
      tick();
      n_checks++; if (bus.ex_valid !== m_valid) begin n_fail++; $display("FAIL rnd%0d ex_valid: got %b expected %b", c, bus.ex_valid, m_valid); end
      n_checks++; if (bus.ex_ctrl !== m_ctrl) begin n_fail++; $display("FAIL rnd%0d ex_ctrl: got %h expected %h", c, bus.ex_ctrl, m_ctrl); end
      if (m_valid) begin
        n_checks++; if (bus.ex_busA !== m_a || bus.ex_busB !== m_b) begin
          n_fail++; $display("FAIL rnd%0d ex_bus: got %h/%h expected %h/%h", c, bus.ex_busA, bus.ex_busB, m_a, m_b); end
        n_checks++; if (bus.ex_imm !== m_imm || bus.ex_rd !== m_rd || bus.ex_pc4 !== m_pc4) begin
          n_fail++; $display("FAIL rnd%0d ex_fields: got %h/%0d/%h expected %h/%0d/%h", c, bus.ex_imm, bus.ex_rd, bus.ex_pc4, m_imm, m_rd, m_pc4); end
      end
      $display("txn %0d: rst=%b flush=%b ex_ready=%b hazard=%b ex_valid=%b ex_rd=%0d", c, rst_now, bus.flush, bus.ex_ready, hz, m_valid, m_rd);
    end
    reset = 1'b1;
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_bypass();
    test_load_use();
    test_backpressure();
    test_flush_hazard();
    test_reset_mid_stall();
    test_imm_targets();
    test_random(600);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/decode_stage_pipelined.md
Name: decode_stage_pipelined

Overview:
Parametrised next-generation instruction decode stage. Holds the architectural register file and produces branch, jump and call targets plus the branch-equality flag. It adds a registered ID/EX pipeline boundary with valid/ready handshake, load-use hazard stall, flush, and a write-back-to-read bypass. It sits between the fetch stage (IF/ID) and the execute stage. Control decoding remains in the external control unit: opcode goes out, the control word comes back.

Parameters:
XLEN, 32, datapath width; must be >= 32.
NUM_REGS, 32, register count; 2..32, index width RAW = clog2(NUM_REGS).
CTRL_W, 24, control word width; must be >= 5.

Ports:
clk  in  1  stage clock
reset  in  1  synchronous, active-low reset
if_valid  in  1  IF/ID holds a valid instruction
if_instr  in  32  instruction: opcode[31:27], rd[26:22], rs1[21:17], rs2[16:12], imm17[16:0], target[26:0]
if_pc4  in  XLEN  PC+4 of the instruction
id_ready  out  1  stage accepts the IF/ID instruction this cycle
opcode  out  5  if_instr[31:27], to control unit
ctrl_in  in  CTRL_W  control word; bit0 ra_dst, bit1 rb_dst, bit2 ext_op, bit3 mem_read, bit4 reg_write, rest pass-through
flush  in  1  kill the instruction in decode
ex_ready  in  1  execute stage accepts the ID/EX contents
wb_we  in  1  write-back enable
wb_rd  in  RAW  write-back register index
wb_data  in  XLEN  write-back data
br_target  out  XLEN  combinational: if_pc4 + (imm_ext << 2), modulo 2^XLEN
jmp_target  out  XLEN  combinational: {if_pc4[XLEN-1:29], target27, 2'b00}
call_rs1  out  XLEN  combinational: busA
eq  out  1  combinational: busA == busB
ex_valid, ex_ctrl, ex_busA, ex_busB, ex_imm, ex_rd, ex_pc4  out  1/CTRL_W/XLEN/XLEN/XLEN/RAW/XLEN  registered ID/EX contents

Behaviour:
- Operand selection: ra = ra_dst ? rd : rs1; rb = rb_dst ? rs2 : rd. Only the low RAW bits of each 5-bit field index the file.
- imm_ext: if ext_op = 1, imm17 is sign-extended to XLEN; otherwise it is zero-extended.
- Register file: NUM_REGS x XLEN. Register 0 always reads 0 and ignores writes. Writes occur on the clk edge when wb_we = 1 and wb_rd != 0.
- Bypass: a read of register r in the same cycle as a write to r (wb_we = 1, r != 0) returns wb_data. busA, busB, eq and call_rs1 all use the bypassed values.
- hazard = if_valid & ex_valid & ex_ctrl[3] & (ex_rd != 0) & (ex_rd == ra | ex_rd == rb).
- id_ready = !reset_active & (flush | (ex_ready & !hazard)).
- ID/EX update per clk edge, highest priority first:
  1. reset == 0: all ex_* outputs clear to 0, and all registers clear to 0.
  2. flush: ex_valid <= 0. The IF/ID instruction is consumed.
  3. !ex_ready: all ex_* outputs hold.
  4. hazard: ex_valid <= 0 (bubble). ex_ctrl <= 0 and the other fields are don't-care. IF/ID is not consumed.
  5. Otherwise: ex_valid <= if_valid. ex_ctrl <= ctrl_in, masked to 0 when if_valid = 0. Data fields load busA, busB, imm_ext, rd, if_pc4.
- Latency: one cycle from IF/ID to ID/EX.
- A load-use hazard costs exactly one bubble. Next cycle the load has left EX, so hazard drops, unless ex_ready is low, in which case the stall persists.
- Simultaneous flush and hazard: flush wins, giving no bubble accounting and id_ready = 1.
- Reset mid-stall or mid-flush: all state is discarded. ex_valid = 0 on the first cycle after release.
- branch/jump targets are purely combinational from IF/ID; the fetch stage owns redirect decisions.

Test Plan:
- Reset: hold reset low 2 cycles, release, read r1..r31 through decode -> all read 0, ex_valid = 0, ex_ctrl = 0.
- Write/bypass: wb_we = 1, wb_rd = 5, wb_data = 0xDEADBEEF in the same cycle as decoding rs1 = 5 -> busA and call_rs1 = 0xDEADBEEF. Next cycle ex_busA = 0xDEADBEEF. A write to r0 -> r0 still reads 0.
- Load-use: ex holds a load (mem_read = 1, rd = 7); decode an instruction with rs1 = 7 -> id_ready = 0, next ex_valid = 0. The following cycle the instruction enters EX, total one bubble.
- Backpressure: ex_ready = 0 for 3 cycles -> ex_* outputs stable, id_ready = 0. ex_ready = 1 -> the pending instruction loads.
- Flush plus hazard the same cycle -> ex_valid = 0 and id_ready = 1.
- Immediate/targets: imm17 = 0x1FFFF, ext_op = 1, if_pc4 = 0x100 -> ex_imm = 0xFFFFFFFF, br_target = 0xFC. With ext_op = 0 -> ex_imm = 0x0001FFFF. With target = 0x10, if_pc4 = 0xE0000000 -> jmp_target = 0xE0000040.
